// File: rtl/branch_prediction_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and registered mispredict/redirect.
// Define BPB_STATS_EN to build the resolved-branch and mispredict statistics counters.
module branch_prediction_buffer #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_compressed,
    input  logic        update_pred_taken,
    input  logic [31:0] update_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int TAG_W = 31 - INDEX_W;

    logic               entry_valid  [ENTRIES];
    logic [TAG_W-1:0]   entry_tag    [ENTRIES];
    logic [1:0]         entry_ctr    [ENTRIES];
    logic [31:0]        entry_target [ENTRIES];

    logic [INDEX_W-1:0] lookup_index;
    logic [TAG_W-1:0]   lookup_tag;
    logic               lookup_hit;

    logic [INDEX_W-1:0] update_index;
    logic [TAG_W-1:0]   update_tag;
    logic               update_hit;
    logic [1:0]         ctr_next;
    logic               update_err;
    logic [31:0]        redirect_next;

    // Bit 0 never takes part in indexing; compressed code is handled through bit 1.
    logic               unused_pc_bits;
    assign unused_pc_bits = lookup_pc[0] ^ update_pc[0];

    assign lookup_index = lookup_pc[INDEX_W:1];
    assign lookup_tag   = lookup_pc[31:INDEX_W+1];
    assign update_index = update_pc[INDEX_W:1];
    assign update_tag   = update_pc[31:INDEX_W+1];

    always_comb begin
        lookup_hit     = entry_valid[lookup_index] && (entry_tag[lookup_index] == lookup_tag);
        predict_taken  = lookup_hit && entry_ctr[lookup_index][1];
        predict_target = predict_taken ? entry_target[lookup_index] : 32'd0;
    end

    always_comb begin
        update_hit    = entry_valid[update_index] && (entry_tag[update_index] == update_tag);
        ctr_next      = entry_ctr[update_index];
        if (update_taken) begin
            if (entry_ctr[update_index] != 2'b11) ctr_next = entry_ctr[update_index] + 2'b01;
        end else begin
            if (entry_ctr[update_index] != 2'b00) ctr_next = entry_ctr[update_index] - 2'b01;
        end
        update_err    = (update_taken != update_pred_taken) ||
                        (update_taken && (update_pred_target != update_target));
        redirect_next = update_taken ? update_target
                                     : update_pc + (update_compressed ? 32'd2 : 32'd4);
    end

    // Table writes happen at the edge, so a same-cycle lookup still sees the old entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i]  <= 1'b0;
                entry_tag[i]    <= '0;
                entry_ctr[i]    <= 2'b01;
                entry_target[i] <= 32'd0;
            end
        end else if (update_valid) begin
            if (update_hit) begin
                entry_ctr[update_index] <= ctr_next;
                if (update_taken) entry_target[update_index] <= update_target;
            end else if (update_taken) begin
                entry_valid[update_index]  <= 1'b1;
                entry_tag[update_index]    <= update_tag;
                entry_ctr[update_index]    <= 2'b10;
                entry_target[update_index] <= update_target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            mispredict <= update_valid && update_err;
            if (update_valid) redirect_pc <= redirect_next;
        end
    end

`ifdef BPB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else if (update_valid) begin
            if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
            if (update_err && (stat_mispredicts != 32'hFFFF_FFFF))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
